// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: a 16-line direct-mapped write-back cache, one word per line,
// that stalls the pipeline through lock while it writes back a dirty victim and refills from main memory.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_is_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        lock,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] valid_q, valid_d;
  logic [15:0] dirty_q, dirty_d;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];

  logic [3:0]  idx;
  logic [25:0] req_tag;
  logic [31:0] line;
  logic [7:0]  lane_byte;
  logic [31:0] store_word;
  logic        hit;
  logic        line_we;
  logic [31:0] line_wdata;

  assign idx     = req_addr[5:2];
  assign req_tag = req_addr[31:6];
  assign line    = data_q[idx];
  assign hit     = req_valid && valid_q[idx] && (tag_q[idx] == req_tag);

  // Byte lanes are little-endian: offset 0 is bits [7:0].
  always_comb begin
    lane_byte  = line[{req_addr[1:0], 3'b000} +: 8];
    load_data  = req_is_word ? line : {{24{lane_byte[7]}}, lane_byte};
    store_word = line;
    if (req_is_word) store_word = req_wdata;
    else             store_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
  end

  // NOTE: every output and next-state signal gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    line_wdata = store_word;
    lock       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (req_we) begin
              line_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            lock    = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        lock      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx, 2'b00};
        mem_wdata = line;
        if (mem_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = REFILL;
        end
      end
      REFILL: begin
        lock     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_addr[31:2], 2'b00};
        if (mem_ready) begin
          line_we      = 1'b1;
          line_wdata   = mem_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; cleared valid bits hide their contents.
  always_ff @(posedge clk) begin
    if (!rst_b && line_we) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= line_wdata;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_b, input, 1, synchronous, active-high reset (asserted = 1).
REQ-003 SHALL have port req_valid, input, 1, a MEM-stage access is present (EX/MEM is_nop_mem low and load or store).
REQ-004 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have port req_is_word, input, 1, 1 = word access, 0 = byte access.
REQ-006 SHALL have port req_addr, input, 32, byte address (ALU_result_mem).
REQ-007 SHALL have port req_wdata, input, 32, store data (rt_data_mem); byte stores use bits [7:0].
REQ-008 SHALL have port load_data, output, 32, load result, valid when req_valid && !req_we && !lock.
REQ-009 SHALL have port lock, output, 1, stall; holds all pipeline buffers while 1.
REQ-010 SHALL have ports mem_req, mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_rdata (input, 32), mem_ready (input, 1): main-memory handshake.

Function
REQ-011 SHALL contain a 16-line direct-mapped write-back cache, one 32-bit word per line: index = req_addr[5:2], tag = req_addr[31:6], per-line valid and dirty bits.
REQ-012 SHALL define hit = req_valid && valid[index] && tag[index] == req_addr[31:6].
REQ-013 SHALL implement FSM states IDLE, WRITEBACK, REFILL.
REQ-014 IDLE, no request: lock = 0, mem_req = 0, no state change.
REQ-015 IDLE, hit: lock = 0, zero extra latency; load_data combinational from the line; a store updates the line at the clock edge and sets dirty.
REQ-016 Word load SHALL return the full word; byte load SHALL return the byte selected by req_addr[1:0] (0 = bits [7:0], little-endian), sign-extended to 32 bits.
REQ-017 Byte store SHALL replace only the lane selected by req_addr[1:0]; the other three bytes are unchanged.
REQ-018 IDLE, miss: lock = 1 combinationally in the same cycle; next state is WRITEBACK if the victim line is valid and dirty, else REFILL.
REQ-019 WRITEBACK: lock = 1, mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim word; on mem_ready, the dirty bit clears and the FSM moves to REFILL.
REQ-020 REFILL: lock = 1, mem_req = 1, mem_we = 0, mem_addr = {req_addr[31:2], 2'b00}; on mem_ready, install mem_rdata, set valid, clear dirty, set the tag, and return to IDLE.
REQ-021 After REFILL the held request SHALL re-evaluate in IDLE as a hit (lock = 0) and complete there; store merging happens only on this hit.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the cycle mem_ready is sampled 1.
REQ-023 mem_ready SHALL be ignored while mem_req = 0.
REQ-024 A clean miss with mem_ready on the k-th REFILL cycle SHALL give exactly 1+k lock-high cycles.
REQ-025 A dirty miss SHALL give 1 + kw + kr lock-high cycles, where kw and kr are the WRITEBACK and REFILL wait counts.
REQ-026 A mem_ready that arrives in the first WRITEBACK or REFILL cycle (k = 1) SHALL be legal.
REQ-027 req_valid dropping mid-miss is illegal, because lock holds the buffer; behaviour under it is unspecified.
REQ-028 Back-to-back hits to the same line SHALL see the prior store's data with no bubble.

Reset
REQ-029 While rst_b = 1 at a clock edge: state = IDLE and all valid and dirty bits are cleared; tag and data contents are don't-care.
REQ-030 After reset: lock = 0 when req_valid = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-031 Reset asserted in WRITEBACK or REFILL SHALL abandon the transfer; mem_req = 0 from the next cycle; no line is installed.

Verification
REQ-032 Reset, then word load at 0x0000_0040 with mem_rdata = 0xDEAD_BEEF, mem_ready on the 3rd REFILL cycle -> lock high for 4 cycles; next cycle load_data = 0xDEAD_BEEF, lock = 0.
REQ-033 After REQ-032, byte store 0x0000_00AA at 0x0000_0041, then word load at 0x40 -> both hits, lock = 0; load_data = 0xDEAD_AAEF.
REQ-034 After REQ-033, load at 0x0000_0080 (same index 0, new tag) -> WRITEBACK with mem_addr = 0x40 and mem_wdata = 0xDEAD_AAEF, then REFILL with mem_addr = 0x80.
REQ-035 Byte load at 0x0000_0043 of a line holding 0x80FF_0000 -> load_data = 0xFFFF_FF80.
REQ-036 Assert rst_b during REFILL -> next cycle mem_req = 0, state = IDLE; a re-access to the same address misses again.
REQ-037 mem_ready pulsed while mem_req = 0 -> no state, valid or data change.
